freq_meter_autorange: RTL and testbench
=======================================

Name: freq_meter_autorange

Overview:
Parametrised successor of the fixed 4-digit frequency meter core. It counts rising edges of an asynchronous input over a programmable gate window using N_DIGITS cascaded BCD decades. A decade prescaler is selected either manually or by auto-ranging with overflow/underrange logic. Each result is latched with its range and overflow status, and the 7-segment display stage downstream consumes the latched BCD vector.

Parameters:
N_DIGITS, 4, number of BCD decades counted and latched (2..8)
N_RANGES, 3, number of prescaler ranges; range r divides input edges by 10^r (1..4)
GATE_CYCLES, 50_000_000, sys_clk cycles per gate window (1 s at 50 MHz)
RANGE_W, derived $clog2(N_RANGES) min 1, width of range fields

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous active-low reset
sig_in  in  1  asynchronous signal under test
auto_en  in  1  1 = auto-range, 0 = manual range
man_range  in  RANGE_W  manual range select, clamped to N_RANGES-1
bcd_out  out  4*N_DIGITS  latched count, digit 0 in [3:0]
range_out  out  RANGE_W  range used for latched count
overflow  out  1  latched count saturated
meas_valid  out  1  one-cycle pulse when new result latched

Behaviour:
- Reset (async, reset=0): bcd_out=0, range_out=0, overflow=0, meas_valid=0, active range=0, counters/prescaler cleared, FSM=CLEAR.
- Input path: 2-FF synchroniser plus rising-edge detect gives 1-cycle edge pulse; usable input frequency < sys_clk/4.
- FSM: CLEAR (1 cycle) -> GATE (exactly GATE_CYCLES cycles) -> LATCH (1 cycle) -> CLEAR. Measurement period is GATE_CYCLES+2.
- CLEAR: zero BCD decades, prescaler and gate timer; apply next_range as the active range.
- GATE: edge pulse advances the decade prescaler. In range r, the BCD count increments once per 10^r edges (r=0: every edge). Edges seen in CLEAR/LATCH are dropped.
- BCD cascade: each decade rolls 9->0 with carry. When all digits are 9 and an increment arrives, the count holds at all-9s and the internal ovf flag sets sticky for the gate.
- LATCH: bcd_out <= count, range_out <= active range, overflow <= ovf, meas_valid=1 for this cycle only. next_range is computed here.
- next_range, auto_en=1:
  - ovf and range < N_RANGES-1 -> range+1.
  - else not ovf, top digit==0, range>0 -> range-1.
  - else unchanged.
  - Steps are one range per measurement only.
- next_range, auto_en=0: min(man_range, N_RANGES-1). auto_en and man_range are sampled only in LATCH.
- Overflow at the top range in auto mode: range stays, overflow=1, bcd_out all 9s.
- Outputs hold between LATCH cycles. No partial results are ever visible.
- Reset asserted mid-gate aborts the measurement. After release, the first result arrives GATE_CYCLES+2 cycles later, in range 0.

Decomposition:
- Package freq_meter_pkg holds:
  - FSM state enum (CLEAR, GATE, LATCH)
  - BCD_MAX constant 4'd9
  - range-width helper function
- Sub-module bcd_decade: one 4-bit decade with inc, clr, hold (saturate), and carry out. Instantiated N_DIGITS times in a generate loop.
- Prescaler reuses bcd_decade instances (N_RANGES-1 of them). Their chained carry, selected by active range, forms the count enable.

Test Plan:
- Bench params: N_DIGITS=2, N_RANGES=3, GATE_CYCLES=1000, sig_in driven synchronous to sys_clk.
- Reset: hold reset=0 with sig toggling -> all outputs 0. Release -> first meas_valid exactly 1002 cycles after release.
- Basic count: auto_en=0, man_range=0, sig period 20 cycles -> bcd_out=8'h50 (±1 LSB), range_out=0, overflow=0. meas_valid high 1 cycle every 1002 cycles.
- Auto up-range: auto_en=1, sig period 4 -> measurement 1: bcd_out=8'h99, overflow=1, range_out=0. Measurement 2: bcd_out=8'h25 (±1), overflow=0, range_out=1.
- Auto down-range: from range 1, switch to sig period 100 -> measurement in range 1: bcd_out=8'h01, range_out=1. Next measurement: bcd_out=8'h10, range_out=0.
- Top-range saturation: auto_en=0, man_range=3 (clamped to 2), sig period 4 -> bcd_out=8'h02, range_out=2. Then N_DIGITS=1 build, sig period 4 at man_range=2 -> bcd_out=4'h2. Force 250 edges with N_DIGITS=1, range 0 -> 4'h9 with overflow=1.
- Mid-gate reset: assert reset at cycle 500 of a gate -> outputs 0 immediately. No meas_valid for 1002 cycles after release, and active range=0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM states, BCD limit and range-width helper for the frequency meter
package freq_meter_pkg;
  typedef enum logic [1:0] {CLEAR, GATE, LATCH} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic int range_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/freq_meter_autorange_bcd_decade.sv
// bcd_decade: one BCD digit with clear, increment, saturating hold and ripple carry
module bcd_decade
  import freq_meter_pkg::*;
(
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic       hold,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = inc && q == BCD_MAX;
  // digit rolls 9->0 unless the whole count is saturated, then it sticks at 9
  always_ff @(posedge sys_clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == BCD_MAX) ? (hold ? q : 4'd0) : q + 4'd1;
endmodule

// File: rtl/freq_meter_autorange.sv
// freq_meter_autorange: gated BCD edge counter with decade prescaler and auto-ranging
module freq_meter_autorange
  import freq_meter_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int N_RANGES    = 3,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int RANGE_W     = range_width(N_RANGES)
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  sig_in,
  input  logic                  auto_en,
  input  logic [RANGE_W-1:0]    man_range,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [RANGE_W-1:0]    range_out,
  output logic                  overflow,
  output logic                  meas_valid
);
  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam logic [RANGE_W-1:0] TOP = RANGE_W'(N_RANGES - 1);
  state_t               state;
  logic [TW-1:0]        timer;
  logic [RANGE_W-1:0]   act_range, next_range, range_next, man_clamp;
  logic                 s1, s2, s3, sig_rise, clr, ovf, sat, top_zero;
  logic [N_RANGES-1:0]  pchain;
  logic [N_DIGITS:0]    dchain;
  logic [N_DIGITS-1:0]  nine;
  logic [4*N_DIGITS-1:0] count;
  logic [3:0]           unused_pre_q [N_RANGES > 1 ? N_RANGES-1 : 1];

  // two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge sys_clk or negedge reset)
    if (!reset) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {sig_in, s1, s2};

  assign sig_rise  = s2 && !s3;
  assign clr       = state == CLEAR;
  assign pchain[0] = sig_rise && state == GATE;

  for (genvar p = 0; p < N_RANGES - 1; p++) begin : g_pre
    bcd_decade u_pre (
      .sys_clk(sys_clk), .reset(reset), .inc(pchain[p]), .clr(clr), .hold(1'b0),
      .q(unused_pre_q[p]), .carry(pchain[p+1])
    );
  end

  assign dchain[0] = pchain[act_range];

  for (genvar d = 0; d < N_DIGITS; d++) begin : g_dig
    bcd_decade u_dig (
      .sys_clk(sys_clk), .reset(reset), .inc(dchain[d]), .clr(clr), .hold(sat),
      .q(count[4*d +: 4]), .carry(dchain[d+1])
    );
    assign nine[d] = count[4*d +: 4] == BCD_MAX;
  end

  assign sat       = &nine;
  assign top_zero  = count[4*N_DIGITS-1 -: 4] == 4'd0;
  assign man_clamp = (man_range > TOP) ? TOP : man_range;
  assign range_next = !auto_en ? man_clamp :
                      (ovf && act_range < TOP) ? act_range + 1'b1 :
                      (!ovf && top_zero && act_range != '0) ? act_range - 1'b1 : act_range;

  // measurement sequencer: clear, count for the gate window, then publish the result
  always_ff @(posedge sys_clk or negedge reset)
    if (!reset) begin
      state      <= CLEAR;
      timer      <= '0;
      act_range  <= '0;
      next_range <= '0;
      ovf        <= 1'b0;
      bcd_out    <= '0;
      range_out  <= '0;
      overflow   <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        CLEAR: begin
          act_range <= next_range;
          timer     <= '0;
          ovf       <= 1'b0;
          state     <= GATE;
        end
        GATE: begin
          if (dchain[N_DIGITS]) ovf <= 1'b1;
          timer <= timer + 1'b1;
          if (timer == TW'(GATE_CYCLES - 1)) state <= LATCH;
        end
        LATCH: begin
          bcd_out    <= count;
          range_out  <= act_range;
          overflow   <= ovf;
          meas_valid <= 1'b1;
          next_range <= range_next;
          state      <= CLEAR;
        end
        default: state <= CLEAR;
      endcase
    end
endmodule

// File: tb/tb_freq_meter_autorange.sv
// tb_freq_meter_autorange: directed checks of counting, auto-ranging, saturation and reset
module tb_freq_meter_autorange;
  logic       sys_clk = 0, reset = 0, sig_in = 0, auto_en = 0;
  logic [1:0] man_range = 0;
  logic [7:0] bcd_a;
  logic [3:0] bcd_b;
  logic [1:0] rng_a, rng_b;
  logic       ovf_a, ovf_b, mv_a, mv_b;
  int per = 20, gcnt = 0, n_vec = 0, n_err = 0, cyc;

  always #5 sys_clk = ~sys_clk;

  freq_meter_autorange #(.N_DIGITS(2), .N_RANGES(3), .GATE_CYCLES(1000)) dut_a (
    .sys_clk(sys_clk), .reset(reset), .sig_in(sig_in), .auto_en(auto_en), .man_range(man_range),
    .bcd_out(bcd_a), .range_out(rng_a), .overflow(ovf_a), .meas_valid(mv_a)
  );

  freq_meter_autorange #(.N_DIGITS(1), .N_RANGES(3), .GATE_CYCLES(1000)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .sig_in(sig_in), .auto_en(auto_en), .man_range(man_range),
    .bcd_out(bcd_b), .range_out(rng_b), .overflow(ovf_b), .meas_valid(mv_b)
  );

  initial forever begin
    @(negedge sys_clk);
    gcnt   = (gcnt >= per - 1) ? 0 : gcnt + 1;
    sig_in = (gcnt >= per / 2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    do begin
      @(negedge sys_clk);
      c++;
    end while (!mv_a && c < 3000);
  endtask

  task automatic release_sync();
    do begin
      @(negedge sys_clk);
      #1;
    end while (gcnt != 0);
    reset = 1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] b, input logic [1:0] r, input logic o);
    check({tag, ".a_bcd"}, bcd_a, b);
    check({tag, ".a_rng"}, rng_a, r);
    check({tag, ".a_ovf"}, ovf_a, o);
  endtask

  task automatic check_b(input string tag, input logic [3:0] b, input logic [1:0] r, input logic o);
    check({tag, ".b_valid"}, mv_b, 1);
    check({tag, ".b_bcd"}, bcd_b, b);
    check({tag, ".b_rng"}, rng_b, r);
    check({tag, ".b_ovf"}, ovf_b, o);
  endtask

  initial begin
    repeat (30) @(negedge sys_clk);
    #1;
    check("rst.bcd_a", bcd_a, 0);
    check("rst.rng_a", rng_a, 0);
    check("rst.ovf_a", ovf_a, 0);
    check("rst.mv_a", mv_a, 0);
    check("rst.bcd_b", bcd_b, 0);
    release_sync();
    wait_valid(cyc);
    check("first_valid", cyc, 1002);
    check_a("m1", 8'h50, 0, 0);
    check_b("m1", 4'h9, 0, 1);
    @(negedge sys_clk);
    check("valid_pulse", mv_a, 0);
    wait_valid(cyc);
    check("period_m2", cyc, 1001);
    check_a("m2", 8'h50, 0, 0);
    auto_en = 1;
    per = 4;
    wait_valid(cyc);
    check("period_m3", cyc, 1002);
    check_a("m3", 8'h99, 0, 1);
    check_b("m3", 4'h9, 0, 1);
    wait_valid(cyc);
    check_a("m4", 8'h25, 1, 0);
    check_b("m4", 4'h9, 1, 1);
    per = 100;
    wait_valid(cyc);
    check_a("m5", 8'h01, 1, 0);
    check_b("m5", 4'h0, 2, 0);
    wait_valid(cyc);
    check_a("m6", 8'h10, 0, 0);
    check_b("m6", 4'h1, 1, 0);
    auto_en = 0;
    man_range = 3;
    per = 4;
    wait_valid(cyc);
    check("period_m7", cyc, 1002);
    wait_valid(cyc);
    check_a("m8", 8'h02, 2, 0);
    check_b("m8", 4'h2, 2, 0);
    man_range = 0;
    wait_valid(cyc);
    check_a("m9", 8'h02, 2, 0);
    man_range = 2;
    wait_valid(cyc);
    check_a("m10", 8'h99, 0, 1);
    check_b("m10", 4'h9, 0, 1);
    repeat (500) @(negedge sys_clk);
    reset = 0;
    #1;
    check("midrst.bcd_a", bcd_a, 0);
    check("midrst.rng_a", rng_a, 0);
    check("midrst.ovf_a", ovf_a, 0);
    check("midrst.mv_a", mv_a, 0);
    check("midrst.bcd_b", bcd_b, 0);
    repeat (10) @(negedge sys_clk);
    release_sync();
    wait_valid(cyc);
    check("midrst_valid", cyc, 1002);
    check_a("m11", 8'h99, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
